// File: rtl/pb_seq_conditioner.sv
// rtl/pb_seq_conditioner.sv - pushbutton sync, debounce, one-shot and auto-repeat for the sequencer
module pb_seq_conditioner #(
  parameter int ACTIVE_LOW      = 1,
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int REPEAT_EN       = 1,
  parameter int REPEAT_DELAY    = 25_000_000,
  parameter int REPEAT_PERIOD   = 5_000_000,
  parameter int CNT_W           = 25
) (
  input  logic CLK_50,
  input  logic reset,
  input  logic pb_up_raw,
  input  logic pb_dn_raw,
  output logic pb_seq_up,
  output logic pb_seq_dn,
  output logic up_held,
  output logic dn_held
);

  // Raw level of a released button; the sync flops park here in reset.
  localparam logic REL = (ACTIVE_LOW != 0);
  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] RP_LAST = CNT_W'(REPEAT_PERIOD - 1);

  typedef enum logic [1:0] {IDLE, DELAY, REPEAT, HOLD} state_t;

  // Index 0 is the up button, index 1 the down button.
  logic [1:0]       raw;
  logic [1:0]       sync1;
  logic [1:0]       sync2;
  logic [1:0]       pressed;
  logic [1:0]       held_i;
  logic [1:0]       req;
  logic [CNT_W-1:0] db_cnt [2];
  logic [CNT_W-1:0] rpt    [2];
  state_t           state  [2];

  assign raw     = {pb_dn_raw, pb_up_raw};
  assign pressed = sync2 ^ {2{REL}};

  // Two-flop synchronizer on the raw pins, nothing else looks at them.
  always_ff @(posedge CLK_50) begin
    if (reset) begin
      sync1 <= {2{REL}};
      sync2 <= {2{REL}};
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
    end
  end

  // Debounce: accept a new level only after DEBOUNCE_CYCLES consecutive disagreeing samples.
  always_ff @(posedge CLK_50) begin
    for (int b = 0; b < 2; b++) begin
      if (reset) begin
        db_cnt[b] <= '0;
        held_i[b] <= 1'b0;
      end else if (pressed[b] == held_i[b]) begin
        db_cnt[b] <= '0;
      end else if (db_cnt[b] == DB_LAST) begin
        held_i[b] <= pressed[b];
        db_cnt[b] <= '0;
      end else begin
        db_cnt[b] <= db_cnt[b] + 1'b1;
      end
    end
  end

  // Per-button press FSM: first pulse on press, then optional delayed auto-repeat while held.
  always_ff @(posedge CLK_50) begin
    for (int b = 0; b < 2; b++) begin
      if (reset) begin
        state[b] <= IDLE;
        rpt[b]   <= '0;
        req[b]   <= 1'b0;
      end else begin
        req[b] <= 1'b0;
        if (!held_i[b]) begin
          state[b] <= IDLE;
          rpt[b]   <= '0;
        end else begin
          case (state[b])
            IDLE: begin
              req[b]   <= 1'b1;
              rpt[b]   <= '0;
              state[b] <= (REPEAT_EN != 0) ? DELAY : HOLD;
            end
            DELAY: begin
              if (rpt[b] == RD_LAST) begin
                req[b]   <= 1'b1;
                rpt[b]   <= '0;
                state[b] <= REPEAT;
              end else begin
                rpt[b] <= rpt[b] + 1'b1;
              end
            end
            REPEAT: begin
              if (rpt[b] == RP_LAST) begin
                req[b] <= 1'b1;
                rpt[b] <= '0;
              end else begin
                rpt[b] <= rpt[b] + 1'b1;
              end
            end
            default: rpt[b] <= '0;
          endcase
        end
      end
    end
  end

  // Registered outputs; a request is dropped while the opposite button is held.
  always_ff @(posedge CLK_50) begin
    if (reset) begin
      pb_seq_up <= 1'b0;
      pb_seq_dn <= 1'b0;
      up_held   <= 1'b0;
      dn_held   <= 1'b0;
    end else begin
      pb_seq_up <= req[0] & ~held_i[1];
      pb_seq_dn <= req[1] & ~held_i[0];
      up_held   <= held_i[0];
      dn_held   <= held_i[1];
    end
  end

endmodule
